// File: rtl/ttm4_pkg.sv
// Shared definitions for the TTM4 program memory: default widths, loader
// state encoding and the read-register reset value.
package ttm4_pkg;

   localparam int unsigned ADDR_W_DEF = 8;
   localparam int unsigned DATA_W_DEF = 8;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_LOAD,
      ST_DONE
   } ld_state_e;

   // Replicated to DATA_W where used.
   localparam logic RD_RST_BIT = 1'b0;

endpackage

// File: rtl/ttm4_prog_ram.sv
// Program RAM: one synchronous write port, one synchronous read-first read
// port, no reset; contents start at zero and are never cleared.
module ttm4_prog_ram
   import ttm4_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W] = '{default: '0};
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata_q <= mem[raddr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/ttm4_prog_mem.sv
// TTM4 program memory: registered instruction fetch on PA, plus a streaming
// loader that rewrites the RAM while holding the CPU off.
module ttm4_prog_mem
   import ttm4_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [ADDR_W-1:0] PA,
   input  logic              nROM_OE,
   output logic [DATA_W-1:0] ROMDATA,
   input  logic              LD_START,
   input  logic              LD_VALID,
   input  logic              LD_LAST,
   input  logic [DATA_W-1:0] LD_DATA,
   output logic              LD_READY,
   output logic              LD_DONE,
   output logic              nCPU_HOLD
);

   ld_state_e         state_q,  state_d;
   logic [ADDR_W-1:0] wptr_q,   wptr_d;
   logic              ready_q,  ready_d;
   logic              done_q,   done_d;
   logic              hold_n_q, hold_n_d;
   logic              rd_vld_q, rd_vld_d;
   logic              we;
   logic [DATA_W-1:0] ram_rdata;
   logic [DATA_W-1:0] rd_word;

   assign we = (state_q == ST_LOAD) && LD_VALID && ready_q;

   ttm4_prog_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_ram (
      .clk   (CLK),
      .we    (we),
      .waddr (wptr_q),
      .wdata (LD_DATA),
      .raddr (PA),
      .rdata (ram_rdata)
   );

   always_comb begin
      state_d  = state_q;
      wptr_d   = wptr_q;
      hold_n_d = hold_n_q;
      done_d   = (state_q == ST_DONE);
      case (state_q)
         ST_RUN: begin
            if (LD_START) begin
               state_d  = ST_LOAD;
               wptr_d   = '0;
               hold_n_d = 1'b0;
            end else if (done_q) begin
               hold_n_d = 1'b1;
            end
         end
         ST_LOAD: begin
            if (we) begin
               wptr_d = ADDR_W'(wptr_q + 1'b1);
               if (LD_LAST || (wptr_q == '1)) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: state_d = ST_RUN;
         default: state_d = ST_RUN;
      endcase
      ready_d  = (state_d == ST_LOAD);
      rd_vld_d = (state_d == ST_RUN);
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q  <= ST_RUN;
         wptr_q   <= '0;
         ready_q  <= 1'b0;
         done_q   <= 1'b0;
         hold_n_q <= 1'b1;
         rd_vld_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         wptr_q   <= wptr_d;
         ready_q  <= ready_d;
         done_q   <= done_d;
         hold_n_q <= hold_n_d;
         rd_vld_q <= rd_vld_d;
      end
   end

   // The resettable valid flag plus the RAM output register together form the
   // read register: it reads as zero after reset and while loading.
   assign rd_word = rd_vld_q ? ram_rdata : {DATA_W{RD_RST_BIT}};

   assign ROMDATA   = nROM_OE ? 'z : rd_word;
   assign LD_READY  = ready_q;
   assign LD_DONE   = done_q;
   assign nCPU_HOLD = hold_n_q;

endmodule
